// File: rtl/xlr8_wdt_pkg.sv
// xlr8_wdt_pkg: shared constants and types for the XLR8 watchdog timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: WDTCSR bit positions, WDP clamp limit, counter width, mode enum,
//           helpers for WDP clamping and mode decode.
package xlr8_wdt_pkg;

  // WDTCSR bit positions (WDP2:0 occupy bits 2:0)
  localparam int WDIF_BIT = 7;
  localparam int WDIE_BIT = 6;
  localparam int WDP3_BIT = 5;
  localparam int WDCE_BIT = 4;
  localparam int WDE_BIT  = 3;

  // Prescaler settings above this behave as this one
  localparam int WDP_MAX = 9;

  // Longest timeout is 2^20 ticks; terminal count 2^20-1 fits in 20 bits
  localparam int CNT_W = 20;

  // Encoded as {WDE, WDIE}
  typedef enum logic [1:0] {
    WDT_STOP    = 2'b00,
    WDT_INT     = 2'b01,
    WDT_RST     = 2'b10,
    WDT_INT_RST = 2'b11
  } wdt_mode_e;

  function automatic logic [3:0] wdp_clamp(input logic [3:0] wdp);
    return (wdp > 4'(WDP_MAX)) ? 4'(WDP_MAX) : wdp;
  endfunction

  function automatic wdt_mode_e wdt_mode(input logic wde, input logic wdie);
    return wdt_mode_e'({wde, wdie});
  endfunction

endpackage

// File: rtl/xlr8_wdt_if.sv
// xlr8_wdt_if: extended data-memory bus as seen by a single-register peripheral.
// Latency: reads are combinational, writes land on the next clk_cpu edge.
// Backpressure: none; every access is accepted in the cycle it is presented.
// Signals: ramadr/ramre/ramwe/dm_sel/dbus_in driven by the core (master),
//          dbus_out/io_out_en driven by the peripheral (slave).
interface xlr8_wdt_if;

  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic       dm_sel;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       io_out_en;

  modport master (
    output ramadr, ramre, ramwe, dm_sel, dbus_in,
    input  dbus_out, io_out_en
  );

  modport slave (
    input  ramadr, ramre, ramwe, dm_sel, dbus_in,
    output dbus_out, io_out_en
  );

endinterface

// File: rtl/xlr8_wdt_prescaler.sv
// xlr8_wdt_prescaler: 20-bit en128khz tick counter with WDP-selected terminal count.
// Latency: timeout is combinational in the terminal tick cycle; count updates next edge.
// Backpressure: none; every tick is counted while run is high.
// Ports: clk_cpu, core_rstn; en128khz tick strobe; clr synchronous clear (wins over
//        a would-be timeout); run enable (low holds count at 0); wdp 4-bit
//        prescaler select; timeout single-cycle pulse.
module xlr8_wdt_prescaler
  import xlr8_wdt_pkg::*;
#(
  parameter int TIMEOUT_BASE = 2048
) (
  input  logic       clk_cpu,
  input  logic       core_rstn,
  input  logic       en128khz,
  input  logic       clr,
  input  logic       run,
  input  logic [3:0] wdp,
  output logic       timeout
);

  localparam logic [CNT_W:0] BASE_V = (CNT_W + 1)'(TIMEOUT_BASE);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   span;
  logic [CNT_W-1:0] term;
  logic             at_term;

  // span may be exactly 2^20, hence one extra bit; term always fits CNT_W
  always_comb begin
    span = BASE_V << wdp_clamp(wdp);
    term = CNT_W'(span - (CNT_W + 1)'(1));
  end

  assign at_term = (cnt == term);
  assign timeout = en128khz && run && !clr && at_term;

  always_ff @(posedge clk_cpu or negedge core_rstn) begin
    if (!core_rstn) begin
      cnt <= '0;
    end else if (clr || !run) begin
      cnt <= '0;
    end else if (en128khz) begin
      cnt <= at_term ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/xlr8_wdt.sv
// xlr8_wdt: AVR WDTCSR-compatible watchdog (interrupt, reset, or interrupt-then-reset).
// Latency: writes take effect next cycle; WDIF/wdt_rst assert one cycle after the terminal tick.
// Backpressure: none; bus accesses, wdr and acks are always accepted.
// Ports: clk_cpu, core_rstn; en128khz tick strobe; dm data-memory bus (slave);
//        wdr restart strobe; wdt_irq_ack interrupt vector ack; wdt_irq = WDIF & WDIE;
//        wdt_rst one-cycle reset request.
module xlr8_wdt
  import xlr8_wdt_pkg::*;
#(
  parameter logic [7:0] WDTCSR_ADDR  = 8'h60,
  parameter int         TIMEOUT_BASE = 2048
) (
  input  logic         clk_cpu,
  input  logic         core_rstn,
  input  logic         en128khz,
  xlr8_wdt_if.slave    dm,
  input  logic         wdr,
  input  logic         wdt_irq_ack,
  output logic         wdt_irq,
  output logic         wdt_rst
);

  // Register state
  logic       wdif, wdie, wde, wdce;
  logic [3:0] wdp;
  logic [1:0] win_cnt;

  // Next-state
  logic       wdif_nxt, wdie_nxt, wde_nxt, wdce_nxt, rst_nxt;
  logic [3:0] wdp_nxt;
  logic [1:0] win_nxt;

  logic       sel, wr, rd;
  logic [7:0] din;
  logic [7:0] csr;
  wdt_mode_e  mode;
  logic       run, run_nxt;
  logic       presc_clr;
  logic       timeout;

  // ---------------- bus decode ----------------
  assign din = dm.dbus_in;
  assign sel = dm.dm_sel && (dm.ramadr == WDTCSR_ADDR);
  assign wr  = sel && dm.ramwe;
  assign rd  = sel && dm.ramre;

  assign csr = {wdif, wdie, wdp[3], wdce, wde, wdp[2:0]};

  assign dm.io_out_en = rd;
  assign dm.dbus_out  = rd ? csr : 8'h00;

  assign mode    = wdt_mode(wde, wdie);
  assign run     = (mode != WDT_STOP);
  assign wdt_irq = wdif && wdie;

  // ---------------- control register / timed sequence ----------------
  // wdce doubles as "window open"; win_cnt counts the 4 open cycles 3..0.
  always_comb begin
    wde_nxt  = wde;
    wdp_nxt  = wdp;
    wdce_nxt = wdce;
    win_nxt  = win_cnt;
    wdie_nxt = wdie;

    if (wr) begin
      if (wdce) begin
        // In-window: WDE/WDP freely writable; this write consumes the window
        wde_nxt  = din[WDE_BIT];
        wdp_nxt  = {din[WDP3_BIT], din[2:0]};
        wdce_nxt = 1'b0;
        win_nxt  = 2'd0;
      end else begin
        // Outside: WDE can only be set, WDP is locked
        wde_nxt = wde | din[WDE_BIT];
        if (din[WDCE_BIT] && din[WDE_BIT]) begin
          wdce_nxt = 1'b1;
          win_nxt  = 2'd3;
        end
      end
    end else if (wdce) begin
      if (win_cnt == 2'd0) begin
        wdce_nxt = 1'b0;
      end else begin
        win_nxt = win_cnt - 2'd1;
      end
    end

    if (wr) begin
      wdie_nxt = din[WDIE_BIT];
    end
    // Ack in a reset-capable mode drops WDIE so the next timeout resets
    if (wdt_irq_ack && wde) begin
      wdie_nxt = 1'b0;
    end

    run_nxt = wde_nxt | wdie_nxt;
    // Restart counting on wdr, on a prescaler change, or on start-up from stopped
    presc_clr = wdr || (wr && ((wdp_nxt != wdp) || (!run && run_nxt)));
  end

  // ---------------- timeout actions ----------------
  // Kept apart from the block above: timeout depends on presc_clr.
  always_comb begin
    wdif_nxt = wdif;
    rst_nxt  = 1'b0;

    if ((wr && din[WDIF_BIT]) || wdt_irq_ack) begin
      wdif_nxt = 1'b0;
    end

    // Set follows clear so a coincident timeout wins
    case (mode)
      WDT_INT, WDT_INT_RST: begin
        if (timeout) begin
          wdif_nxt = 1'b1;
        end
      end
      WDT_RST: begin
        rst_nxt = timeout;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_cpu or negedge core_rstn) begin
    if (!core_rstn) begin
      wdif    <= 1'b0;
      wdie    <= 1'b0;
      wde     <= 1'b0;
      wdce    <= 1'b0;
      wdp     <= 4'd0;
      win_cnt <= 2'd0;
      wdt_rst <= 1'b0;
    end else begin
      wdif    <= wdif_nxt;
      wdie    <= wdie_nxt;
      wde     <= wde_nxt;
      wdce    <= wdce_nxt;
      wdp     <= wdp_nxt;
      win_cnt <= win_nxt;
      wdt_rst <= rst_nxt;
    end
  end

  xlr8_wdt_prescaler #(
    .TIMEOUT_BASE (TIMEOUT_BASE)
  ) u_presc (
    .clk_cpu   (clk_cpu),
    .core_rstn (core_rstn),
    .en128khz  (en128khz),
    .clr       (presc_clr),
    .run       (run),
    .wdp       (wdp),
    .timeout   (timeout)
  );

endmodule

// File: tb/tb_xlr8_wdt.sv
// tb_xlr8_wdt: scoreboard bench for xlr8_wdt with a scaled TIMEOUT_BASE of 64.
// Expected wdt_rst/wdt_irq events and read data are queued as stimulus is driven
// and popped by a negedge monitor when the DUT produces them.
module tb_xlr8_wdt;

  localparam int          BASE  = 64;
  localparam logic [7:0]  ADDR  = 8'h60;
  localparam logic [1:0]  EV_RST = 2'd1;
  localparam logic [1:0]  EV_IRQ = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
  } evt_t;

  typedef struct packed {
    logic       en;
    logic [7:0] dat;
  } rd_t;

  logic clk_cpu     = 1'b0;
  logic core_rstn   = 1'b0;
  logic en128khz    = 1'b0;
  logic wdr         = 1'b0;
  logic wdt_irq_ack = 1'b0;
  logic wdt_irq;
  logic wdt_rst;

  xlr8_wdt_if bus();

  xlr8_wdt #(
    .WDTCSR_ADDR  (ADDR),
    .TIMEOUT_BASE (BASE)
  ) dut (
    .clk_cpu     (clk_cpu),
    .core_rstn   (core_rstn),
    .en128khz    (en128khz),
    .dm          (bus),
    .wdr         (wdr),
    .wdt_irq_ack (wdt_irq_ack),
    .wdt_irq     (wdt_irq),
    .wdt_rst     (wdt_rst)
  );

  always #5 clk_cpu = ~clk_cpu;

  int unsigned cyc = 0;
  always @(posedge clk_cpu) cyc <= cyc + 1;

  evt_t evq[$];
  rd_t  rq[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   rd_act = 1'b0;
  bit   irq_q = 1'b0;
  rd_t  mon_r;

  // Reference model of the counter and mode
  int   m_cnt = 0;
  int   m_tmo = BASE;
  bit   m_wde = 1'b0;
  bit   m_wdie = 1'b0;
  bit   m_wdif = 1'b0;
  int   gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic got_evt(input logic [1:0] kind);
    evt_t e;
    if (evq.size() == 0) begin
      chk("evt_unexpected", 32'(kind), 32'd0);
    end else begin
      e = evq.pop_front();
      chk("evt_kind", 32'(kind), 32'(e.kind));
      chk("evt_cyc", cyc, e.cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk_cpu) begin
    if (rd_act) begin
      if (rq.size() == 0) begin
        chk("rd_underflow", 32'd1, 32'd0);
      end else begin
        mon_r = rq.pop_front();
        chk("rd_en", 32'(bus.io_out_en), 32'(mon_r.en));
        chk("rd_dat", 32'(bus.dbus_out), 32'(mon_r.dat));
      end
    end
    if (wdt_rst === 1'b1) got_evt(EV_RST);
    if (wdt_irq === 1'b1 && !irq_q) got_evt(EV_IRQ);
    irq_q = (wdt_irq === 1'b1);
  end

  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] d);
    bus.dm_sel  = 1'b1;
    bus.ramwe   = 1'b1;
    bus.ramadr  = ADDR;
    bus.dbus_in = d;
    step();
    bus.ramwe  = 1'b0;
    bus.dm_sel = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic sel, input logic en_exp,
                        input logic [7:0] d_exp);
    rd_t r;
    r.en  = en_exp;
    r.dat = d_exp;
    rq.push_back(r);
    bus.dm_sel = sel;
    bus.ramre  = 1'b1;
    bus.ramadr = a;
    rd_act     = 1'b1;
    step();
    bus.ramre  = 1'b0;
    bus.dm_sel = 1'b0;
    rd_act     = 1'b0;
  endtask

  task automatic csr_rd(input logic [7:0] d_exp);
    bus_rd(ADDR, 1'b1, 1'b1, d_exp);
  endtask

  // One en128khz tick, optionally with wdr; the model predicts any event
  task automatic tick(input bit with_wdr);
    evt_t e;
    en128khz = 1'b1;
    wdr      = with_wdr;
    if (with_wdr || !(m_wde || m_wdie)) begin
      m_cnt = 0;
    end else if (m_cnt == m_tmo - 1) begin
      m_cnt = 0;
      e.cyc = cyc + 1;
      if (m_wdie) begin
        if (!m_wdif) begin
          e.kind = EV_IRQ;
          evq.push_back(e);
        end
        m_wdif = 1'b1;
      end else begin
        e.kind = EV_RST;
        evq.push_back(e);
      end
    end else begin
      m_cnt++;
    end
    step();
    en128khz = 1'b0;
    wdr      = 1'b0;
    repeat (gap) step();
  endtask

  task automatic model_clear();
    m_cnt  = 0;
    m_tmo  = BASE;
    m_wde  = 1'b0;
    m_wdie = 1'b0;
    m_wdif = 1'b0;
  endtask

  task automatic do_reset();
    core_rstn = 1'b0;
    step();
    step();
    core_rstn = 1'b1;
    model_clear();
    step();
  endtask

  task automatic settle();
    repeat (4) step();
    chk("evt_missing", 32'(evq.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL time_limit: simulation bound reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    bus.ramadr  = 8'h00;
    bus.ramre   = 1'b0;
    bus.ramwe   = 1'b0;
    bus.dm_sel  = 1'b0;
    bus.dbus_in = 8'h00;

    // ---- reset state and read path ----
    core_rstn = 1'b0;
    repeat (3) step();
    chk("rst_irq", 32'(wdt_irq), 32'd0);
    chk("rst_rst", 32'(wdt_rst), 32'd0);
    chk("rst_cnt", 32'(dut.u_presc.cnt), 32'd0);
    core_rstn = 1'b1;
    step();
    csr_rd(8'h00);
    bus_rd(8'h61, 1'b1, 1'b0, 8'h00);
    bus_rd(ADDR, 1'b0, 1'b0, 8'h00);

    // ---- reset mode, WDP=0, sparse ticks ----
    do_reset();
    bus_wr(8'h18);
    bus_wr(8'h08);
    csr_rd(8'h08);
    m_wde = 1'b1;
    m_tmo = BASE;
    gap   = 2;
    repeat (BASE) tick(1'b0);
    settle();
    gap = 0;

    // ---- stay alive with wdr; period 4 puts wdr on the terminal tick ----
    for (int p = 0; p < 10; p++) begin
      int n;
      n = (p == 4) ? BASE : BASE - 4;
      repeat (n - 1) tick(1'b0);
      tick(1'b1);
    end
    settle();
    chk("alive_rst_low", 32'(wdt_rst), 32'd0);

    // ---- interrupt-then-reset, WDP=1 ----
    do_reset();
    bus_wr(8'h18);
    bus_wr(8'h49);
    csr_rd(8'h49);
    m_wde  = 1'b1;
    m_wdie = 1'b1;
    m_tmo  = 2 * BASE;
    repeat (2 * BASE) tick(1'b0);
    step();
    chk("ir_irq_hi", 32'(wdt_irq), 32'd1);
    csr_rd(8'hC9);
    wdt_irq_ack = 1'b1;
    step();
    wdt_irq_ack = 1'b0;
    m_wdif = 1'b0;
    m_wdie = 1'b0;
    csr_rd(8'h09);
    chk("ir_irq_lo", 32'(wdt_irq), 32'd0);
    repeat (2 * BASE) tick(1'b0);
    settle();

    // ---- timed-sequence rules ----
    do_reset();
    bus_wr(8'h08);
    csr_rd(8'h08);
    bus_wr(8'h00);
    csr_rd(8'h08);
    bus_wr(8'h0F);
    csr_rd(8'h08);
    bus_wr(8'h18);
    repeat (4) step();
    bus_wr(8'h00);
    csr_rd(8'h08);
    bus_wr(8'h18);
    repeat (3) step();
    bus_wr(8'h00);
    csr_rd(8'h00);
    bus_wr(8'h08);
    bus_wr(8'h18);
    csr_rd(8'h18);
    bus_wr(8'h00);
    csr_rd(8'h00);
    settle();

    // ---- WDP=15 clamps to 9, interrupt mode ----
    do_reset();
    bus_wr(8'h18);
    bus_wr(8'h67);
    csr_rd(8'h67);
    m_wdie = 1'b1;
    m_tmo  = BASE << 9;
    repeat (BASE << 9) tick(1'b0);
    step();
    chk("cl_irq_hi", 32'(wdt_irq), 32'd1);
    csr_rd(8'hE7);
    bus_wr(8'hC0);
    m_wdif = 1'b0;
    csr_rd(8'h67);
    settle();

    // ---- reset mid-count ----
    do_reset();
    bus_wr(8'h18);
    bus_wr(8'h67);
    m_wdie = 1'b1;
    m_tmo  = BASE << 9;
    repeat (15625) tick(1'b0);
    core_rstn = 1'b0;
    #1;
    chk("mr_cnt_async", 32'(dut.u_presc.cnt), 32'd0);
    chk("mr_irq", 32'(wdt_irq), 32'd0);
    step();
    core_rstn = 1'b1;
    model_clear();
    step();
    csr_rd(8'h00);
    repeat (2000) tick(1'b0);
    chk("mr_cnt_idle", 32'(dut.u_presc.cnt), 32'd0);
    settle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
